lsu_param: RTL and testbench

Parametrised load-store unit, one instance per thread in each core. Executes LDR/STR against the per-thread data-memory channel with a valid/ready handshake and configurable address and data widths. It latches the operation when the request is accepted and has an optional response timeout. It reports illegal and timed-out accesses through an error flag instead of stalling the core forever.

---
 rtl/lsu_param.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_param.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_param.sv
// Parametrised load-store unit: one LDR/STR at a time over a valid/ready memory channel,
// with an optional WAITING timeout and an error flag for illegal or abandoned accesses.
module lsu_param #(
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [ADDR_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  localparam logic [2:0] CoreRequest = 3'b011;
  localparam logic [2:0] CoreUpdate  = 3'b110;

  localparam bit          TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TimeoutLast = TimeoutEn ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StRequesting = 2'd1,
    StWaiting    = 2'd2,
    StDone       = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    OpNone  = 2'd0,
    OpRead  = 2'd1,
    OpWrite = 2'd2
  } lsu_op_e;

  lsu_state_e state_q, state_d;
  lsu_op_e    op_q, op_d;

  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [ADDR_BITS-1:0] raddr_q, raddr_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [DATA_BITS-1:0] wout_q, wout_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 err_q, err_d;
  logic [15:0]          cnt_q, cnt_d;

  logic req_cycle;
  logic legal_req;
  logic illegal_req;
  logic ready_sel;
  logic timeout_hit;

  always_comb begin
    req_cycle   = (core_state == CoreRequest);
    legal_req   = req_cycle && (decoded_mem_read_enable ^ decoded_mem_write_enable);
    illegal_req = req_cycle && decoded_mem_read_enable && decoded_mem_write_enable;
    // Only the channel of the latched op may complete the access.
    unique case (op_q)
      OpRead:  ready_sel = mem_read_ready;
      OpWrite: ready_sel = mem_write_ready;
      default: ready_sel = 1'b0;
    endcase
    timeout_hit = TimeoutEn && (cnt_q == TimeoutLast);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (illegal_req) begin
          state_d = StDone;
        end else if (legal_req) begin
          state_d = StRequesting;
        end
      end
      StRequesting: state_d = StWaiting;
      StWaiting: begin
        if (ready_sel || timeout_hit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (core_state == CoreUpdate) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: valid is a decode of WAITING plus the latched op, so it freezes with the FSM.
  always_comb begin
    lsu_state         = state_q;
    mem_read_valid    = (state_q == StWaiting) && (op_q == OpRead);
    mem_write_valid   = (state_q == StWaiting) && (op_q == OpWrite);
    mem_read_address  = raddr_q;
    mem_write_address = waddr_q;
    mem_write_data    = wout_q;
    lsu_out           = out_q;
    lsu_error         = err_q;
  end

  // Datapath next-state
  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wout_d  = wout_q;
    out_d   = out_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (illegal_req) begin
          err_d = 1'b1;
        end else if (legal_req) begin
          op_d    = decoded_mem_read_enable ? OpRead : OpWrite;
          addr_d  = rs;
          wdata_d = rt;
          err_d   = 1'b0;
        end
      end
      StRequesting: begin
        cnt_d = 16'd0;
        if (op_q == OpRead) begin
          raddr_d = addr_q;
        end else if (op_q == OpWrite) begin
          waddr_d = addr_q;
          wout_d  = wdata_q;
        end
      end
      StWaiting: begin
        if (ready_sel) begin
          if (op_q == OpRead) begin
            out_d = mem_read_data;
          end
        end else begin
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
          if (timeout_hit) begin
            err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OpNone;
      addr_q  <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      wout_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else if (enable) begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wout_q  <= wout_d;
      out_q   <= out_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lsu_param.sv
// Bench for lsu_param: a narrow instance with a 4-cycle timeout and a wide instance with no
// timeout run the same transactions in lockstep against a transaction-level outcome model.
module tb_lsu_param;

  localparam logic [2:0] Req     = 3'b011;
  localparam logic [2:0] Upd     = 3'b110;
  localparam int         TSmall  = 4;
  localparam int         MaxIter = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [2:0]  core_state = 3'b000;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] rs = '0;
  logic [31:0] rt = '0;
  logic        read_ready = 1'b0;
  logic        write_ready = 1'b0;
  logic [31:0] read_data = '0;

  logic        s_rv, s_wv, s_err;
  logic [7:0]  s_ra, s_wa, s_wd, s_out;
  logic [1:0]  s_st;
  logic        w_rv, w_wv, w_err;
  logic [15:0] w_ra, w_wa;
  logic [31:0] w_wd, w_out;
  logic [1:0]  w_st;

  lsu_param #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(TSmall)) u_small (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .rs                       (rs[7:0]),
    .rt                       (rt[7:0]),
    .mem_read_valid           (s_rv),
    .mem_read_address         (s_ra),
    .mem_read_ready           (read_ready),
    .mem_read_data            (read_data[7:0]),
    .mem_write_valid          (s_wv),
    .mem_write_address        (s_wa),
    .mem_write_data           (s_wd),
    .mem_write_ready          (write_ready),
    .lsu_state                (s_st),
    .lsu_out                  (s_out),
    .lsu_error                (s_err)
  );

  lsu_param #(.ADDR_BITS(16), .DATA_BITS(32), .TIMEOUT_CYCLES(0)) u_wide (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .rs                       (rs),
    .rt                       (rt),
    .mem_read_valid           (w_rv),
    .mem_read_address         (w_ra),
    .mem_read_ready           (read_ready),
    .mem_read_data            (read_data),
    .mem_write_valid          (w_wv),
    .mem_write_address        (w_wa),
    .mem_write_data           (w_wd),
    .mem_write_ready          (write_ready),
    .lsu_state                (w_st),
    .lsu_out                  (w_out),
    .lsu_error                (w_err)
  );

  logic [1:0]  st[2];
  logic        rv[2], wv[2], er[2];
  logic [63:0] ra[2], wa[2], wd[2], lo[2];

  always_comb begin
    st[0] = s_st;        st[1] = w_st;
    rv[0] = s_rv;        rv[1] = w_rv;
    wv[0] = s_wv;        wv[1] = w_wv;
    er[0] = s_err;       er[1] = w_err;
    ra[0] = 64'(s_ra);   ra[1] = 64'(w_ra);
    wa[0] = 64'(s_wa);   wa[1] = 64'(w_wa);
    wd[0] = 64'(s_wd);   wd[1] = 64'(w_wd);
    lo[0] = 64'(s_out);  lo[1] = 64'(w_out);
  end

  // Architectural model of what each instance should be showing.
  logic [63:0] m_out[2], m_ra[2], m_wa[2], m_wd[2];
  logic        m_err[2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] amask(int j);
    return (j == 0) ? 64'hFF : 64'hFFFF;
  endfunction

  function automatic logic [63:0] dmask(int j);
    return (j == 0) ? 64'hFF : 64'hFFFF_FFFF;
  endfunction

  function automatic logic [2:0] busy_cs();
    logic [2:0] c;
    c = 3'($urandom_range(0, 7));
    if (c == Upd) c = 3'b000;
    return c;
  endfunction

  task automatic check_regs(input string tag, input logic [1:0] e0, input logic [1:0] e1);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("%s st%0d", tag, j), 64'(st[j]), (j == 0) ? 64'(e0) : 64'(e1));
      check($sformatf("%s err%0d", tag, j), 64'(er[j]), 64'(m_err[j]));
      check($sformatf("%s out%0d", tag, j), lo[j], m_out[j]);
      check($sformatf("%s raddr%0d", tag, j), ra[j], m_ra[j]);
      check($sformatf("%s waddr%0d", tag, j), wa[j], m_wa[j]);
      check($sformatf("%s wdata%0d", tag, j), wd[j], m_wd[j]);
    end
  endtask

  task automatic do_reset(input string tag);
    core_state  = 3'b000;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    read_ready  = 1'b0;
    write_ready = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 2; j++) begin
      m_out[j] = '0; m_ra[j] = '0; m_wa[j] = '0; m_wd[j] = '0; m_err[j] = 1'b0;
    end
    check_regs(tag, 2'd0, 2'd0);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("%s rvalid%0d", tag, j), 64'(rv[j]), 64'(0));
      check($sformatf("%s wvalid%0d", tag, j), 64'(wv[j]), 64'(0));
    end
  endtask

  // op: 0 LDR, 1 STR, 2 both enables, 3 neither. k: ready raised on the k-th valid cycle
  // (0 = never).
  task automatic run_txn(input int op, input logic [15:0] a, input logic [31:0] d,
                         input logic [31:0] rdata, input int k, input bit freeze,
                         input string tag);
    int         vc[2];
    int         wrong[2];
    bit         done[2];
    bit         ok[2];
    logic [1:0] est[2];
    bit         chan_v;
    for (int j = 0; j < 2; j++) begin
      vc[j] = 0; wrong[j] = 0; done[j] = 1'b0;
    end
    @(negedge clk);
    rs          = a;
    rt          = d;
    rd_en       = (op == 0 || op == 2);
    wr_en       = (op == 1 || op == 2);
    core_state  = Req;
    read_ready  = 1'b0;
    write_ready = 1'b0;
    @(negedge clk);
    if (op == 3) begin
      for (int j = 0; j < 2; j++)
        check($sformatf("%s idle st%0d", tag, j), 64'(st[j]), 64'(0));
      core_state = 3'b000;
      return;
    end
    // Scramble the request inputs: the latched access must not notice.
    core_state = busy_cs();
    rs         = 16'($urandom);
    rt         = $urandom;
    rd_en      = 1'($urandom);
    wr_en      = 1'($urandom);
    if (op == 2) begin
      for (int j = 0; j < 2; j++) begin
        check($sformatf("%s rvalid%0d", tag, j), 64'(rv[j]), 64'(0));
        check($sformatf("%s wvalid%0d", tag, j), 64'(wv[j]), 64'(0));
        m_err[j] = 1'b1;
      end
      check_regs(tag, 2'd3, 2'd3);
    end else begin
      for (int j = 0; j < 2; j++) begin
        check($sformatf("%s req st%0d", tag, j), 64'(st[j]), 64'(1));
        check($sformatf("%s req valid%0d", tag, j), 64'(rv[j] | wv[j]), 64'(0));
        check($sformatf("%s req err%0d", tag, j), 64'(er[j]), 64'(0));
        m_err[j] = 1'b0;
      end
      @(negedge clk);
      if (freeze) begin
        enable = 1'b0;
        repeat (5) begin
          @(negedge clk);
          for (int j = 0; j < 2; j++) begin
            chan_v = (op == 0) ? rv[j] : wv[j];
            check($sformatf("%s frz st%0d", tag, j), 64'(st[j]), 64'(2));
            check($sformatf("%s frz valid%0d", tag, j), 64'(chan_v), 64'(1));
          end
        end
        enable = 1'b1;
      end
      for (int i = 1; i <= MaxIter; i++) begin
        for (int j = 0; j < 2; j++) begin
          if (!done[j]) begin
            if (st[j] == 2'd3) done[j] = 1'b1;
            else begin
              if ((op == 0) ? rv[j] : wv[j]) vc[j]++;
              if ((op == 0) ? wv[j] : rv[j]) wrong[j]++;
            end
          end
        end
        if (done[0] && done[1]) break;
        if (op == 0) begin
          read_ready  = (k != 0 && i >= k);
          write_ready = 1'($urandom);
        end else begin
          write_ready = (k != 0 && i >= k);
          read_ready  = 1'($urandom);
        end
        read_data = (op == 0 && read_ready) ? rdata : $urandom;
        @(negedge clk);
      end
      for (int j = 0; j < 2; j++) begin
        ok[j]  = (k != 0) && (j == 1 || k <= TSmall);
        est[j] = (j == 1 && k == 0) ? 2'd2 : 2'd3;
        check($sformatf("%s vcycles%0d", tag, j), 64'(vc[j]),
              64'(ok[j] ? k : ((j == 0) ? TSmall : MaxIter)));
        check($sformatf("%s wrongch%0d", tag, j), 64'(wrong[j]), 64'(0));
        if (op == 0) m_ra[j] = 64'(a) & amask(j);
        else begin
          m_wa[j] = 64'(a) & amask(j);
          m_wd[j] = 64'(d) & dmask(j);
        end
        if (ok[j] && op == 0) m_out[j] = 64'(rdata) & dmask(j);
        m_err[j] = (est[j] == 2'd3) && !ok[j];
        chan_v = (op == 0) ? rv[j] : wv[j];
        check($sformatf("%s end valid%0d", tag, j), 64'(chan_v), 64'(est[j] == 2'd2));
      end
      check_regs(tag, est[0], est[1]);
    end
    read_ready  = 1'b0;
    write_ready = 1'b0;
    if (op != 2 && k == 0) begin
      do_reset({tag, " rst"});
    end else begin
      core_state = busy_cs();
      @(negedge clk);
      for (int j = 0; j < 2; j++)
        check($sformatf("%s hold st%0d", tag, j), 64'(st[j]), 64'(3));
      core_state = Upd;
      @(negedge clk);
      for (int j = 0; j < 2; j++)
        check($sformatf("%s upd st%0d", tag, j), 64'(st[j]), 64'(0));
      core_state = 3'b000;
      rd_en      = 1'b0;
      wr_en      = 1'b0;
    end
  endtask

  initial begin
    int r, op, k;
    bit frz;
    do_reset("reset");
    run_txn(0, 16'h002A, 32'h0, 32'h0000_005C, 3, 1'b0, "load");
    run_txn(1, 16'h0010, 32'h0000_00EE, 32'h0, 1, 1'b0, "store");
    run_txn(2, 16'h0055, 32'h0000_0011, 32'h0, 1, 1'b0, "illegal");
    run_txn(0, 16'h0044, 32'h0, 32'h0000_00A7, 2, 1'b0, "clr_err");
    run_txn(0, 16'h0033, 32'h0, 32'h0000_0077, 0, 1'b0, "timeout");
    run_txn(0, 16'hBEEF, 32'h0, 32'hDEAD_BEEF, 2, 1'b1, "wide");
    run_txn(1, 16'h1234, 32'hCAFE_F00D, 32'h0, 4, 1'b0, "st_t4");
    run_txn(0, 16'h00F0, 32'h0, 32'h0000_0099, 5, 1'b0, "ld_t5");
    run_txn(3, 16'h0000, 32'h0, 32'h0, 1, 1'b0, "none");
    for (int n = 0; n < 40; n++) begin
      r   = int'($urandom_range(0, 9));
      op  = (r < 4) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
      k   = ($urandom_range(0, 12) == 0) ? 0 : int'($urandom_range(1, 6));
      frz = ($urandom_range(0, 4) == 0);
      run_txn(op, 16'($urandom), $urandom, $urandom, k, frz, $sformatf("rnd%0d", n));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
